// File: rtl/axi_lite_mem_responder_pkg.sv
// Shared definitions for the AXI4-Lite memory responder: response codes,
// read/write state encodings and a small response helper.
package axi_lite_mem_responder_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ACCESS,
      R_RESP
   } rd_state_t;

   typedef enum logic [1:0] {
      W_COLLECT,
      W_COMMIT,
      W_RESP
   } wr_state_t;

   function automatic axi_resp_t respFor(input logic inRange);
      return inRange ? RESP_OKAY : RESP_SLVERR;
   endfunction

endpackage

// File: rtl/bram_byte_we.sv
// Simple dual-port 32-bit RAM with per-byte write enables, read-first
// behaviour and a registered read port, written so it maps onto block RAM.
module bram_byte_we #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata
);

   logic [31:0] r_mem [0:(2**AW)-1];
   logic [31:0] r_rdata;

   // Read and write share one clocked block so a same-address access returns the old word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (i_we[i]) begin
            r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite slave in front of a byte-writable word RAM; independent read and
// write paths, each handling one transaction at a time.
module axi_lite_mem_responder
   import axi_lite_mem_responder_pkg::*;
#(
   parameter int          WORD_AW   = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] axi_araddr,
   input  logic        axi_arvalid,
   input  logic [2:0]  axi_arprot,
   output logic        axi_arready,
   output logic [31:0] axi_rdata,
   output logic [1:0]  axi_rresp,
   output logic        axi_rvalid,
   input  logic        axi_rready,
   input  logic [31:0] axi_awaddr,
   input  logic        axi_awvalid,
   input  logic [2:0]  axi_awprot,
   output logic        axi_awready,
   input  logic [31:0] axi_wdata,
   input  logic [3:0]  axi_wstrb,
   input  logic        axi_wvalid,
   output logic        axi_wready,
   output logic [1:0]  axi_bresp,
   output logic        axi_bvalid,
   input  logic        axi_bready
);

   // Offsets are computed one bit wider so an address below the base wraps to a huge value.
   localparam logic [32:0] LIMIT = 33'd4 << WORD_AW;

   logic [32:0]        w_arOff;
   logic [32:0]        w_awOff;
   logic [31:0]        w_ramRdata;
   logic               w_ramRe;
   logic [3:0]         w_ramWe;
   logic               w_awTake;
   logic               w_wTake;
   logic               w_awHeldNext;
   logic               w_wHeldNext;
   logic               w_unused;

   rd_state_t          r_rdState;
   logic               r_arready;
   logic               r_rvalid;
   axi_resp_t          r_rresp;
   logic               r_rdInRange;
   logic [WORD_AW-1:0] r_rdIndex;

   wr_state_t          r_wrState;
   logic               r_awready;
   logic               r_wready;
   logic               r_bvalid;
   axi_resp_t          r_bresp;
   logic               r_awHeld;
   logic               r_wHeld;
   logic               r_wrInRange;
   logic [WORD_AW-1:0] r_wrIndex;
   logic [31:0]        r_wdata;
   logic [3:0]         r_wstrb;

   assign w_unused = ^{axi_arprot, axi_awprot};

   assign w_arOff = {1'b0, axi_araddr} - {1'b0, BASE_ADDR};
   assign w_awOff = {1'b0, axi_awaddr} - {1'b0, BASE_ADDR};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdState   <= R_IDLE;
         r_arready   <= 1'b0;
         r_rvalid    <= 1'b0;
         r_rresp     <= RESP_OKAY;
         r_rdInRange <= 1'b0;
         r_rdIndex   <= '0;
      end else begin
         case (r_rdState)
            R_IDLE: begin
               r_arready <= 1'b1;
               if (axi_arvalid && r_arready) begin
                  r_rdIndex   <= w_arOff[WORD_AW+1:2];
                  r_rdInRange <= (w_arOff < LIMIT);
                  r_arready   <= 1'b0;
                  r_rdState   <= R_ACCESS;
               end
            end
            R_ACCESS: begin
               r_rvalid  <= 1'b1;
               r_rresp   <= respFor(r_rdInRange);
               r_rdState <= R_RESP;
            end
            R_RESP: begin
               if (axi_rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rdState <= R_IDLE;
               end
            end
            default: begin
               r_rdState <= R_IDLE;
            end
         endcase
      end
   end

   assign w_awTake     = axi_awvalid && r_awready;
   assign w_wTake      = axi_wvalid && r_wready;
   assign w_awHeldNext = r_awHeld || w_awTake;
   assign w_wHeldNext  = r_wHeld || w_wTake;

   // Address and data are collected independently; each ready drops once its half is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrState   <= W_COLLECT;
         r_awready   <= 1'b0;
         r_wready    <= 1'b0;
         r_bvalid    <= 1'b0;
         r_bresp     <= RESP_OKAY;
         r_awHeld    <= 1'b0;
         r_wHeld     <= 1'b0;
         r_wrInRange <= 1'b0;
         r_wrIndex   <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
      end else begin
         case (r_wrState)
            W_COLLECT: begin
               if (w_awTake) begin
                  r_wrIndex   <= w_awOff[WORD_AW+1:2];
                  r_wrInRange <= (w_awOff < LIMIT);
                  r_awHeld    <= 1'b1;
               end
               if (w_wTake) begin
                  r_wdata <= axi_wdata;
                  r_wstrb <= axi_wstrb;
                  r_wHeld <= 1'b1;
               end
               if (w_awHeldNext && w_wHeldNext) begin
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_wrState <= W_COMMIT;
               end else begin
                  r_awready <= !w_awHeldNext;
                  r_wready  <= !w_wHeldNext;
               end
            end
            W_COMMIT: begin
               r_bvalid  <= 1'b1;
               r_bresp   <= respFor(r_wrInRange);
               r_wrState <= W_RESP;
            end
            W_RESP: begin
               if (axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awHeld  <= 1'b0;
                  r_wHeld   <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wrState <= W_COLLECT;
               end
            end
            default: begin
               r_wrState <= W_COLLECT;
            end
         endcase
      end
   end

   assign w_ramRe = (r_rdState == R_ACCESS);
   assign w_ramWe = ((r_wrState == W_COMMIT) && r_wrInRange) ? r_wstrb : 4'b0000;

   bram_byte_we #(
      .AW (WORD_AW)
   ) u_ram (
      .clk     (clk),
      .i_re    (w_ramRe),
      .i_raddr (r_rdIndex),
      .o_rdata (w_ramRdata),
      .i_we    (w_ramWe),
      .i_waddr (r_wrIndex),
      .i_wdata (r_wdata)
   );

   // The RAM output holds between reads, so it can drive rdata directly while rvalid is up.
   assign axi_rdata   = (r_rvalid && r_rdInRange) ? w_ramRdata : 32'h0;
   assign axi_arready = r_arready;
   assign axi_rvalid  = r_rvalid;
   assign axi_rresp   = r_rresp;
   assign axi_awready = r_awready;
   assign axi_wready  = r_wready;
   assign axi_bvalid  = r_bvalid;
   assign axi_bresp   = r_bresp;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Scenario and randomized checks of the AXI4-Lite memory responder against
// fixed expectations and a word-array reference model.
module tb_axi_lite_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] axi_araddr = '0;
   logic        axi_arvalid = 1'b0;
   logic [2:0]  axi_arprot = '0;
   logic        axi_arready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rvalid;
   logic        axi_rready = 1'b1;
   logic [31:0] axi_awaddr = '0;
   logic        axi_awvalid = 1'b0;
   logic [2:0]  axi_awprot = '0;
   logic        axi_awready;
   logic [31:0] axi_wdata = '0;
   logic [3:0]  axi_wstrb = '0;
   logic        axi_wvalid = 1'b0;
   logic        axi_wready;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready = 1'b1;

   int testCount = 0;
   int failCount = 0;

   logic [31:0] model [int];

   always #5 clk = ~clk;

   axi_lite_mem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .axi_araddr  (axi_araddr),
      .axi_arvalid (axi_arvalid),
      .axi_arprot  (axi_arprot),
      .axi_arready (axi_arready),
      .axi_rdata   (axi_rdata),
      .axi_rresp   (axi_rresp),
      .axi_rvalid  (axi_rvalid),
      .axi_rready  (axi_rready),
      .axi_awaddr  (axi_awaddr),
      .axi_awvalid (axi_awvalid),
      .axi_awprot  (axi_awprot),
      .axi_awready (axi_awready),
      .axi_wdata   (axi_wdata),
      .axi_wstrb   (axi_wstrb),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .axi_bresp   (axi_bresp),
      .axi_bvalid  (axi_bvalid),
      .axi_bready  (axi_bready)
   );

   // Full write transaction with bounded waits; a timeout counts as a failure.
   task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
      logic awHs;
      logic wHs;
      bit   done;
      resp = 2'bxx;
      axi_awaddr = addr; axi_awvalid = 1'b1;
      axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1;
      axi_bready = 1'b1;
      for (int c = 0; c < 20 && (axi_awvalid || axi_wvalid); c++) begin
         awHs = axi_awvalid && axi_awready;
         wHs = axi_wvalid && axi_wready;
         @(negedge clk);
         if (awHs) axi_awvalid = 1'b0;
         if (wHs) axi_wvalid = 1'b0;
      end
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (axi_bvalid) begin
            resp = axi_bresp;
            done = 1'b1;
         end
         @(negedge clk);
      end
      if (axi_awvalid || axi_wvalid || !done) begin
         testCount++; failCount++;
         $display("[TB] FAIL write_timeout addr=%h", addr);
         axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      end
   endtask

   task automatic applyRead(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
      logic arHs;
      bit   done;
      data = 'x; resp = 2'bxx;
      axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = 1'b1;
      for (int c = 0; c < 20 && axi_arvalid; c++) begin
         arHs = axi_arready;
         @(negedge clk);
         if (arHs) axi_arvalid = 1'b0;
      end
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (axi_rvalid) begin
            data = axi_rdata; resp = axi_rresp;
            done = 1'b1;
         end
         @(negedge clk);
      end
      if (axi_arvalid || !done) begin
         testCount++; failCount++;
         $display("[TB] FAIL read_timeout addr=%h", addr);
         axi_arvalid = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      testCount++;
      if ({axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid} !== 5'b0) begin
         failCount++;
         $display("[TB] FAIL reset_handshakes got=%b want=00000",
                  {axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid});
      end
      testCount++;
      if ({axi_rdata, axi_rresp, axi_bresp} !== 36'h0) begin
         failCount++;
         $display("[TB] FAIL reset_data rdata=%h rresp=%b bresp=%b want zero",
                  axi_rdata, axi_rresp, axi_bresp);
      end
      rst = 1'b0;
      @(negedge clk);
      testCount++;
      if ({axi_arready, axi_awready, axi_wready} !== 3'b111) begin
         failCount++;
         $display("[TB] FAIL reset_release_readies got=%b want=111",
                  {axi_arready, axi_awready, axi_wready});
      end
   endtask

   task automatic test_write_same_cycle();
      axi_awaddr = 32'h10; axi_awvalid = 1'b1;
      axi_wdata = 32'hDEADBEEF; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      axi_bready = 1'b1;
      @(negedge clk);
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      testCount++;
      if ({axi_bvalid, axi_awready, axi_wready} !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL same_cycle_accept bvalid/awready/wready=%b want=000",
                  {axi_bvalid, axi_awready, axi_wready});
      end
      @(negedge clk);
      testCount++;
      if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b00) begin
         failCount++;
         $display("[TB] FAIL same_cycle_bresp bvalid=%b bresp=%b want 1/00",
                  axi_bvalid, axi_bresp);
      end
      @(negedge clk);
      testCount++;
      if ({axi_bvalid, axi_awready, axi_wready} !== 3'b011) begin
         failCount++;
         $display("[TB] FAIL same_cycle_after_b got=%b want=011",
                  {axi_bvalid, axi_awready, axi_wready});
      end
   endtask

   task automatic test_write_w_first();
      logic [31:0] data;
      logic [1:0]  resp;
      bit          done;
      axi_wdata = 32'h0000_1234; axi_wstrb = 4'b0011; axi_wvalid = 1'b1;
      @(negedge clk);
      axi_wvalid = 1'b0;
      testCount++;
      if ({axi_awready, axi_wready} !== 2'b10) begin
         failCount++;
         $display("[TB] FAIL w_first_readies awready/wready=%b want=10",
                  {axi_awready, axi_wready});
      end
      axi_awaddr = 32'h10; axi_awvalid = 1'b1;
      @(negedge clk);
      axi_awvalid = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         if (axi_bvalid) begin
            resp = axi_bresp;
            done = 1'b1;
         end
         @(negedge clk);
      end
      testCount++;
      if (!done || resp !== 2'b00) begin
         failCount++;
         $display("[TB] FAIL w_first_bresp seen=%0d bresp=%b want 1/00", done, resp);
      end
      applyRead(32'h10, data, resp);
      testCount++;
      if (data !== 32'hDEAD1234 || resp !== 2'b00) begin
         failCount++;
         $display("[TB] FAIL strobe_merge rdata=%h rresp=%b want DEAD1234/00", data, resp);
      end
   endtask

   task automatic test_read_backpressure();
      axi_rready = 1'b0;
      axi_araddr = 32'h10; axi_arvalid = 1'b1;
      @(negedge clk);
      axi_arvalid = 1'b0;
      testCount++;
      if (axi_rvalid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL read_latency_early rvalid=%b want 0", axi_rvalid);
      end
      @(negedge clk);
      testCount++;
      if (axi_rvalid !== 1'b1 || axi_rdata !== 32'hDEAD1234) begin
         failCount++;
         $display("[TB] FAIL read_latency rvalid=%b rdata=%h want 1/DEAD1234",
                  axi_rvalid, axi_rdata);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         testCount++;
         if (axi_rvalid !== 1'b1 || axi_rdata !== 32'hDEAD1234 || axi_arready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL read_hold cycle=%0d rvalid=%b rdata=%h arready=%b want 1/DEAD1234/0",
                     c, axi_rvalid, axi_rdata, axi_arready);
         end
      end
      axi_rready = 1'b1;
      @(negedge clk);
      testCount++;
      if (axi_rvalid !== 1'b0 || axi_arready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL read_single_beat rvalid=%b arready=%b want 0/1",
                  axi_rvalid, axi_arready);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] data;
      logic [1:0]  resp;
      applyWrite(32'h0, 32'h0102_0304, 4'hF, resp);
      applyWrite(32'h4000, 32'h1111_1111, 4'hF, resp);
      testCount++;
      if (resp !== 2'b10) begin
         failCount++;
         $display("[TB] FAIL oor_bresp got=%b want=10", resp);
      end
      applyRead(32'h4000, data, resp);
      testCount++;
      if (data !== 32'h0 || resp !== 2'b10) begin
         failCount++;
         $display("[TB] FAIL oor_read rdata=%h rresp=%b want 00000000/10", data, resp);
      end
      applyRead(32'h0, data, resp);
      testCount++;
      if (data !== 32'h0102_0304 || resp !== 2'b00) begin
         failCount++;
         $display("[TB] FAIL oor_no_alias rdata=%h rresp=%b want 01020304/00", data, resp);
      end
   endtask

   task automatic test_collision();
      logic [31:0] data;
      logic [1:0]  resp;
      axi_araddr = 32'h10; axi_arvalid = 1'b1;
      axi_awaddr = 32'h10; axi_awvalid = 1'b1;
      axi_wdata = 32'hCAFEF00D; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      axi_rready = 1'b1; axi_bready = 1'b1;
      @(negedge clk);
      axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      @(negedge clk);
      testCount++;
      if (axi_rvalid !== 1'b1 || axi_rdata !== 32'hDEAD1234 || axi_bvalid !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL collision_old rvalid=%b rdata=%h bvalid=%b want 1/DEAD1234/1",
                  axi_rvalid, axi_rdata, axi_bvalid);
      end
      @(negedge clk);
      applyRead(32'h10, data, resp);
      testCount++;
      if (data !== 32'hCAFEF00D) begin
         failCount++;
         $display("[TB] FAIL collision_new rdata=%h want CAFEF00D", data);
      end
   endtask

   task automatic test_back_to_back();
      int arHs = 0, rBeats = 0, awHs = 0, bBeats = 0;
      axi_rready = 1'b1; axi_bready = 1'b1;
      axi_araddr = 32'h10; axi_arvalid = 1'b1;
      axi_awaddr = 32'h200; axi_awvalid = 1'b1;
      axi_wdata = 32'h600D_CAFE; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (axi_arready) arHs++;
         if (axi_rvalid) rBeats++;
         if (axi_awready && axi_wready) awHs++;
         if (axi_bvalid) bBeats++;
         @(negedge clk);
      end
      axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      model[32'h200 >> 2] = 32'h600D_CAFE;
      testCount++;
      if (arHs != 3 || rBeats != 3) begin
         failCount++;
         $display("[TB] FAIL read_throughput ar=%0d r=%0d want 3/3", arHs, rBeats);
      end
      testCount++;
      if (awHs != 3 || bBeats != 3) begin
         failCount++;
         $display("[TB] FAIL write_throughput aw=%0d b=%0d want 3/3", awHs, bBeats);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] data, addr, mask, wd;
      logic [1:0]  resp;
      logic [3:0]  strb;
      int          idx;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         applyWrite(32'h100 + 32'(i * 4), wd, 4'hF, resp);
         model[(32'h100 >> 2) + i] = wd;
      end
      for (int n = 0; n < 60; n++) begin
         idx = $urandom_range(0, 15);
         addr = 32'h100 + 32'(idx * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            wd = $urandom;
            strb = 4'($urandom_range(0, 15));
            mask = 32'h0;
            for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
            applyWrite(addr, wd, strb, resp);
            model[(32'h100 >> 2) + idx] = (model[(32'h100 >> 2) + idx] & ~mask) | (wd & mask);
            testCount++;
            if (resp !== 2'b00) begin
               failCount++;
               $display("[TB] FAIL rand_bresp addr=%h got=%b want=00", addr, resp);
            end
         end else begin
            applyRead(addr, data, resp);
            testCount++;
            if (data !== model[(32'h100 >> 2) + idx] || resp !== 2'b00) begin
               failCount++;
               $display("[TB] FAIL rand_read addr=%h got=%h/%b want=%h/00",
                        addr, data, resp, model[(32'h100 >> 2) + idx]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      axi_rready = 1'b0; axi_bready = 1'b0;
      axi_awaddr = 32'h20; axi_wdata = 32'h5A5A_5A5A; axi_wstrb = 4'hF;
      axi_awvalid = 1'b1; axi_wvalid = 1'b1;
      @(negedge clk);
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      axi_araddr = 32'h10; axi_arvalid = 1'b1;
      @(negedge clk);
      axi_arvalid = 1'b0;
      testCount++;
      if (axi_bvalid !== 1'b1 || axi_rvalid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL pre_reset_state bvalid=%b rvalid=%b want 1/0", axi_bvalid, axi_rvalid);
      end
      rst = 1'b1;
      #1;
      testCount++;
      if ({axi_bvalid, axi_rvalid, axi_arready, axi_awready, axi_wready} !== 5'b0) begin
         failCount++;
         $display("[TB] FAIL mid_reset_drop got=%b want=00000",
                  {axi_bvalid, axi_rvalid, axi_arready, axi_awready, axi_wready});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      axi_rready = 1'b1; axi_bready = 1'b1;
      @(negedge clk);
      testCount++;
      if ({axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid} !== 5'b11100) begin
         failCount++;
         $display("[TB] FAIL post_reset got=%b want=11100",
                  {axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid});
      end
      @(negedge clk);
      testCount++;
      if (axi_rvalid !== 1'b0 || axi_bvalid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL no_stale_response rvalid=%b bvalid=%b want 0/0", axi_rvalid, axi_bvalid);
      end
   endtask

   initial begin
      test_reset();
      test_write_same_cycle();
      test_write_w_first();
      test_read_backpressure();
      test_out_of_range();
      test_collision();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
